// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, one bit per clock, LSB first.
// The operands are captured on an accepted start. Each SHIFT cycle adds one bit
// pair with a full adder, built as two half-adders plus an OR, through a
// registered carry. The sum is assembled in a shift accumulator. Only the
// completed value is copied to sum/carry, and done pulses once.
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request a new addition (accepted only in IDLE)
//   a, b   - WIDTH-bit operands, sampled on the accept edge only
//   busy   - high while in SHIFT or DONE
//   done   - one-cycle pulse, sum/carry valid
//   sum    - registered WIDTH-bit result, held until the next completion
//   carry  - registered carry-out of bit WIDTH-1
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             c_ff;

  // Per-bit full adder built from two half-adders and an OR.
  logic             ha1_s;
  logic             ha1_c;
  logic             ha2_s;
  logic             ha2_c;
  logic             c_nxt;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    ha1_s   = sh_a[0] ^ sh_b[0];
    ha1_c   = sh_a[0] & sh_b[0];
    ha2_s   = ha1_s ^ c_ff;
    ha2_c   = ha1_s & c_ff;
    c_nxt   = ha1_c | ha2_c;
    acc_nxt = {ha2_s, acc[WIDTH-1:1]};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      acc   <= '0;
      cnt   <= '0;
      c_ff  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            acc   <= '0;
            cnt   <= '0;
            c_ff  <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          c_ff <= c_nxt;
          acc  <= acc_nxt;
          sh_a <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b <= {1'b0, sh_b[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          // The last bit lands in acc_nxt, so publish that value rather than acc.
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= acc_nxt;
            carry <= c_nxt;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized
// operations on WIDTH=8 and WIDTH=16 instances against a plain a+b model.
`timescale 1ns/1ps
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8;
  logic [7:0]  a8, b8, sum8;
  logic        busy8, done8, carry8;

  logic        start16;
  logic [15:0] a16, b16, sum16;
  logic        busy16, done16, carry16;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_sum(input int w);
    return (w == 8) ? {24'b0, sum8} : {16'b0, sum16};
  endfunction

  function automatic logic cur_carry(input int w);
    return (w == 8) ? carry8 : carry16;
  endfunction

  function automatic logic cur_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  function automatic logic cur_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  task automatic set_in(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
    if (w == 8) begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start16 = s; a16 = av[15:0]; b16 = bv[15:0];
    end
  endtask

  // One addition. The expected result is plain arithmetic on the operands.
  // With inject set, start is re-asserted in SHIFT cycle 3 and during DONE.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                        input bit inject, input string tag);
    logic [32:0] full;
    logic [31:0] mask, es, hold_s;
    logic        ec, hold_c;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full   = {1'b0, av & mask} + {1'b0, bv & mask};
    es     = full[31:0] & mask;
    ec     = full[w];
    hold_s = cur_sum(w);
    hold_c = cur_carry(w);
    set_in(w, 1'b1, av, bv);
    @(posedge clk); #1;
    // Operands may change after the accept edge without effect.
    set_in(w, 1'b0, $urandom, $urandom);
    check({tag, " busy_accept"}, 64'(cur_busy(w)), 64'd1);
    check({tag, " done_accept"}, 64'(cur_done(w)), 64'd0);
    for (int k = 1; k <= w; k++) begin
      @(posedge clk); #1;
      check({tag, " busy"}, 64'(cur_busy(w)), 64'd1);
      if (k < w) begin
        check({tag, " done_early"}, 64'(cur_done(w)), 64'd0);
        check({tag, " sum_hold"}, 64'(cur_sum(w)), 64'(hold_s));
        check({tag, " carry_hold"}, 64'(cur_carry(w)), 64'(hold_c));
        if (inject && k == 3) set_in(w, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        if (inject && k == 4) set_in(w, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      end else begin
        check({tag, " done"}, 64'(cur_done(w)), 64'd1);
        check({tag, " sum"}, 64'(cur_sum(w)), 64'(es));
        check({tag, " carry"}, 64'(cur_carry(w)), 64'(ec));
        if (inject) set_in(w, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      end
    end
    @(posedge clk); #1;
    set_in(w, 1'b0, 32'h0, 32'h0);
    check({tag, " done_after"}, 64'(cur_done(w)), 64'd0);
    check({tag, " busy_after"}, 64'(cur_busy(w)), 64'd0);
    check({tag, " sum_after"}, 64'(cur_sum(w)), 64'(es));
    if (inject) begin
      @(posedge clk); #1;
      check({tag, " no_restart"}, 64'(cur_busy(w)), 64'd0);
      check({tag, " no_second_done"}, 64'(cur_done(w)), 64'd0);
    end
  endtask

  initial begin
    int pulses;
    int last_pulse;
    rst = 1'b1;
    set_in(8, 1'b0, 32'h0, 32'h0);
    set_in(16, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy8), 64'd0);
    check("reset done", 64'(done8), 64'd0);
    check("reset sum", 64'(sum8), 64'd0);
    check("reset carry", 64'(carry8), 64'd0);
    check("reset sum16", 64'(sum16), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8, 32'h35, 32'h4A, 1'b0, "d35_4a");
    run_op(8, 32'hFF, 32'h01, 1'b0, "dff_01");
    run_op(8, 32'hFF, 32'hFF, 1'b0, "dff_ff");
    run_op(8, 32'h00, 32'h00, 1'b0, "d00_00");
    run_op(8, 32'h12, 32'h34, 1'b1, "inject");

    // Asynchronous reset between edges in SHIFT cycle 4.
    set_in(8, 1'b1, 32'hA5, 32'h3C);
    @(posedge clk); #1;
    set_in(8, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst busy", 64'(busy8), 64'd0);
    check("arst done", 64'(done8), 64'd0);
    check("arst sum", 64'(sum8), 64'd0);
    check("arst carry", 64'(carry8), 64'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("arst no_done", 64'(done8), 64'd0);
      check("arst no_busy", 64'(busy8), 64'd0);
    end
    run_op(8, 32'h01, 32'h01, 1'b0, "post_rst");

    // start held high: back-to-back operations every WIDTH+2 cycles.
    pulses     = 0;
    last_pulse = -1;
    set_in(8, 1'b1, 32'h80, 32'h80);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done8) begin
        pulses++;
        check("hold sum", 64'(sum8), 64'h00);
        check("hold carry", 64'(carry8), 64'd1);
        if (last_pulse >= 0) check("hold period", 64'(c - last_pulse), 64'd10);
        last_pulse = c;
      end
    end
    set_in(8, 1'b0, 32'h0, 32'h0);
    check("hold pulses", 64'(pulses), 64'd3);
    repeat (2) @(posedge clk);
    #1;
    check("hold idle", 64'(busy8), 64'd0);

    for (int n = 0; n < 200; n++) run_op(8, $urandom, $urandom, 1'b0, "rnd8");
    for (int n = 0; n < 200; n++) run_op(16, $urandom, $urandom, 1'b0, "rnd16");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
